bc_datapath: RTL and testbench

Register-and-bus datapath of the BC_I basic computer. It is the consumer end of the controller's BUS_SEL / CTRL_SGNLS interface. It holds AR, PC, DR, AC, IR, TR, E and word memory, all on a 16-bit common bus. Each clock it applies the decoded control word and returns IR to the controller for decode.

---
 rtl/bc_datapath.sv | 215 +++++++++++++++++++++
 tb/tb_bc_datapath.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bc_datapath.sv
// bc_datapath: register-and-bus datapath of the BC_I basic computer.
// Holds AR, PC, DR, AC, IR, TR, E and word memory on one common bus and
// applies one decoded control word per clock.
// Optional macro BC_DP_HOST_PORT_EN adds a host write port into memory
// (host_we / host_addr / host_wdata) that also works while rst is high.
module bc_datapath #(
  parameter int WIDTH      = 16,
  parameter int ADDR_W     = 12,
  parameter int CTRL_LNGTH = 21
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              BUS_SEL,
  input  logic [3*CTRL_LNGTH-1:0] CTRL_SGNLS,
`ifdef BC_DP_HOST_PORT_EN
  input  logic                    host_we,
  input  logic [ADDR_W-1:0]       host_addr,
  input  logic [WIDTH-1:0]        host_wdata,
`endif
  output logic [WIDTH-1:0]        IR,
  output logic [WIDTH-1:0]        AC,
  output logic [ADDR_W-1:0]       AR,
  output logic [ADDR_W-1:0]       PC,
  output logic                    E,
  output logic [WIDTH-1:0]        BUS
);

  localparam int DEPTH = 1 << ADDR_W;

  // Control entry indices
  localparam int C_AR_LD  = 0;
  localparam int C_AR_INR = 1;
  localparam int C_AR_CLR = 2;
  localparam int C_PC_LD  = 3;
  localparam int C_IR_LD  = 4;
  localparam int C_DR_LD  = 5;
  localparam int C_DR_INR = 6;
  localparam int C_DR_CLR = 7;
  localparam int C_TR_LD  = 8;
  localparam int C_AC_LD  = 9;
  localparam int C_AC_INR = 10;
  localparam int C_AC_CLR = 11;
  localparam int C_PC_INR = 12;
  localparam int C_PC_CLR = 13;
  localparam int C_MEM_WR = 14;
  localparam int C_TR_INR = 15;
  localparam int C_TR_CLR = 16;
  localparam int C_E_LD   = 17;
  localparam int C_E_CMP  = 18;
  localparam int C_E_CLR  = 19;
  localparam int C_ALU_OP = 20;

  typedef enum logic [2:0] {
    SRC_ZERO = 3'b000,
    SRC_PC   = 3'b001,
    SRC_AR   = 3'b010,
    SRC_DR   = 3'b011,
    SRC_IR   = 3'b100,
    SRC_AC   = 3'b101,
    SRC_MEM  = 3'b110,
    SRC_TR   = 3'b111
  } bus_src_e;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_DR   = 3'b010,
    ALU_COM  = 3'b011,
    ALU_CIR  = 3'b100,
    ALU_CIL  = 3'b101,
    ALU_HLD0 = 3'b110,
    ALU_HLD1 = 3'b111
  } alu_op_e;

  logic [WIDTH-1:0] DR;
  logic [WIDTH-1:0] TR;
  logic [WIDTH-1:0] mem [0:DEPTH-1];

  logic ar_ld, ar_inr, ar_clr;
  logic pc_ld, pc_inr, pc_clr;
  logic ir_ld;
  logic dr_ld, dr_inr, dr_clr;
  logic tr_ld, tr_inr, tr_clr;
  logic ac_ld, ac_inr, ac_clr;
  logic mem_wr;
  logic e_ld, e_cmp, e_clr;

  bus_src_e         bus_src;
  alu_op_e          alu_op;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic [WIDTH:0]   alu_sum;
  logic             ctrl_unused;

  assign ar_ld  = CTRL_SGNLS[3*C_AR_LD];
  assign ar_inr = CTRL_SGNLS[3*C_AR_INR];
  assign ar_clr = CTRL_SGNLS[3*C_AR_CLR];
  assign pc_ld  = CTRL_SGNLS[3*C_PC_LD];
  assign pc_inr = CTRL_SGNLS[3*C_PC_INR];
  assign pc_clr = CTRL_SGNLS[3*C_PC_CLR];
  assign ir_ld  = CTRL_SGNLS[3*C_IR_LD];
  assign dr_ld  = CTRL_SGNLS[3*C_DR_LD];
  assign dr_inr = CTRL_SGNLS[3*C_DR_INR];
  assign dr_clr = CTRL_SGNLS[3*C_DR_CLR];
  assign tr_ld  = CTRL_SGNLS[3*C_TR_LD];
  assign tr_inr = CTRL_SGNLS[3*C_TR_INR];
  assign tr_clr = CTRL_SGNLS[3*C_TR_CLR];
  assign ac_ld  = CTRL_SGNLS[3*C_AC_LD];
  assign ac_inr = CTRL_SGNLS[3*C_AC_INR];
  assign ac_clr = CTRL_SGNLS[3*C_AC_CLR];
  assign mem_wr = CTRL_SGNLS[3*C_MEM_WR];
  assign e_ld   = CTRL_SGNLS[3*C_E_LD];
  assign e_cmp  = CTRL_SGNLS[3*C_E_CMP];
  assign e_clr  = CTRL_SGNLS[3*C_E_CLR];
  assign alu_op = alu_op_e'(CTRL_SGNLS[3*C_ALU_OP +: 3]);
  assign bus_src = bus_src_e'(BUS_SEL);

  // Upper two bits of every single-bit control entry carry no meaning
  always_comb begin
    ctrl_unused = 1'b0;
    for (int unsigned i = 0; i < CTRL_LNGTH - 1; i++) begin
      ctrl_unused = ctrl_unused ^ (^CTRL_SGNLS[3*i+1 +: 2]);
    end
  end

  // Common bus source multiplexer, 12-bit sources zero-extended
  always_comb begin
    BUS = '0;
    case (bus_src)
      SRC_ZERO: BUS = '0;
      SRC_PC:   BUS = {{(WIDTH-ADDR_W){1'b0}}, PC};
      SRC_AR:   BUS = {{(WIDTH-ADDR_W){1'b0}}, AR};
      SRC_DR:   BUS = DR;
      SRC_IR:   BUS = IR;
      SRC_AC:   BUS = AC;
      SRC_MEM:  BUS = mem[AR];
      SRC_TR:   BUS = TR;
      default:  BUS = '0;
    endcase
  end

  // ALU result and carry out feeding AC LD and E LD
  always_comb begin
    alu_sum  = {1'b0, AC} + {1'b0, DR};
    alu_res  = AC;
    alu_cout = E;
    case (alu_op)
      ALU_AND: begin alu_res = AC & DR;                 alu_cout = 1'b0;        end
      ALU_ADD: begin alu_res = alu_sum[WIDTH-1:0];      alu_cout = alu_sum[WIDTH]; end
      ALU_DR:  begin alu_res = DR;                      alu_cout = 1'b0;        end
      ALU_COM: begin alu_res = ~AC;                     alu_cout = 1'b0;        end
      ALU_CIR: begin alu_res = {E, AC[WIDTH-1:1]};      alu_cout = AC[0];       end
      ALU_CIL: begin alu_res = {AC[WIDTH-2:0], E};      alu_cout = AC[WIDTH-1]; end
      default: begin alu_res = AC;                      alu_cout = E;           end
    endcase
  end

  // AR: CLR > LD > INR
  always_ff @(posedge clk) begin
    if (rst || ar_clr) AR <= '0;
    else if (ar_ld)    AR <= BUS[ADDR_W-1:0];
    else if (ar_inr)   AR <= AR + 1'b1;
  end

  // PC: CLR > LD > INR
  always_ff @(posedge clk) begin
    if (rst || pc_clr) PC <= '0;
    else if (pc_ld)    PC <= BUS[ADDR_W-1:0];
    else if (pc_inr)   PC <= PC + 1'b1;
  end

  // IR: load only
  always_ff @(posedge clk) begin
    if (rst)        IR <= '0;
    else if (ir_ld) IR <= BUS;
  end

  // DR: CLR > LD > INR
  always_ff @(posedge clk) begin
    if (rst || dr_clr) DR <= '0;
    else if (dr_ld)    DR <= BUS;
    else if (dr_inr)   DR <= DR + 1'b1;
  end

  // TR: CLR > LD > INR
  always_ff @(posedge clk) begin
    if (rst || tr_clr) TR <= '0;
    else if (tr_ld)    TR <= BUS;
    else if (tr_inr)   TR <= TR + 1'b1;
  end

  // AC: CLR > LD (from ALU) > INR
  always_ff @(posedge clk) begin
    if (rst || ac_clr) AC <= '0;
    else if (ac_ld)    AC <= alu_res;
    else if (ac_inr)   AC <= AC + 1'b1;
  end

  // E: CLR > LD (ALU carry) > CMP
  always_ff @(posedge clk) begin
    if (rst || e_clr) E <= 1'b0;
    else if (e_ld)    E <= alu_cout;
    else if (e_cmp)   E <= ~E;
  end

  // Memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && mem_wr) mem[AR] <= BUS;
`ifdef BC_DP_HOST_PORT_EN
    // Later non-blocking write to the same address wins the collision
    if (host_we) mem[host_addr] <= host_wdata;
`endif
  end

endmodule

// File: tb/tb_bc_datapath.sv
// tb_bc_datapath: directed-vector scoreboard bench for bc_datapath.
// Stimulus pushes expected bus/register values into a queue tagged with the
// cycle they are due; a negedge monitor pops and compares them.
module tb_bc_datapath;

  localparam int WIDTH = 16;
  localparam int ADDR_W = 12;
  localparam int CTRL_LNGTH = 21;

  localparam int AR_LD = 0,  AR_INR = 1,  AR_CLR = 2,  PC_LD = 3,  IR_LD = 4;
  localparam int DR_LD = 5,  DR_INR = 6,  DR_CLR = 7,  TR_LD = 8,  AC_LD = 9;
  localparam int AC_INR = 10, AC_CLR = 11, PC_INR = 12, PC_CLR = 13, MEM_WR = 14;
  localparam int TR_INR = 15, TR_CLR = 16, E_LD = 17, E_CMP = 18, E_CLR = 19;

  localparam int K_AR = 0, K_PC = 1, K_AC = 2, K_IR = 3, K_E = 4, K_BUS = 5;

  logic                    clk;
  logic                    rst;
  logic [2:0]              bus_sel;
  logic [3*CTRL_LNGTH-1:0] ctrl;
  logic [WIDTH-1:0]        ir, ac, bus;
  logic [ADDR_W-1:0]       ar, pc;
  logic                    e;
`ifdef BC_DP_HOST_PORT_EN
  logic                    host_we;
  logic [ADDR_W-1:0]       host_addr;
  logic [WIDTH-1:0]        host_wdata;
`endif

  bc_datapath #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CTRL_LNGTH(CTRL_LNGTH)) dut (
    .clk(clk),
    .rst(rst),
    .BUS_SEL(bus_sel),
    .CTRL_SGNLS(ctrl),
`ifdef BC_DP_HOST_PORT_EN
    .host_we(host_we),
    .host_addr(host_addr),
    .host_wdata(host_wdata),
`endif
    .IR(ir),
    .AC(ac),
    .AR(ar),
    .PC(pc),
    .E(e),
    .BUS(bus)
  );

  typedef struct {
    int unsigned due;
    int          kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

  function automatic logic [15:0] actual(input int kind);
    case (kind)
      K_AR:    return {4'h0, ar};
      K_PC:    return {4'h0, pc};
      K_AC:    return ac;
      K_IR:    return ir;
      K_E:     return {15'h0, e};
      default: return bus;
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle
  exp_t        cur;
  logic [15:0] act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      act = actual(cur.kind);
      total_cnt++;
      if (cur.due != cyc)
        $display("FAIL %s: missed due cycle %0d (now %0d)", cur.name, cur.due, cyc);
      else if (act === cur.val)
        pass_cnt++;
      else
        $display("FAIL %s: got 0x%04h expected 0x%04h (cycle %0d)", cur.name, act, cur.val, cyc);
    end
  end

  function automatic logic [20:0] b(input int i);
    logic [20:0] one;
    one = 21'd1;
    return one << i;
  endfunction

  task automatic exp_now(input int kind, input logic [15:0] v, input string n);
    sb.push_back('{due: cyc, kind: kind, val: v, name: n});
  endtask

  task automatic exp_next(input int kind, input logic [15:0] v, input string n);
    sb.push_back('{due: cyc + 1, kind: kind, val: v, name: n});
  endtask

  // Drive one control word for one cycle; bits [2:1] of single-bit entries
  // carry junk that the datapath must ignore
  task automatic step(input logic r, input logic [2:0] sel, input logic [20:0] mask,
                      input logic [2:0] op);
    @(posedge clk);
    #1;
    rst = r;
    bus_sel = sel;
    for (int i = 0; i < 20; i++) ctrl[3*i +: 3] = {2'b10, mask[i]};
    ctrl[60 +: 3] = op;
  endtask

  logic [15:0] wr_val;

  initial begin
    rst = 1'b1;
    bus_sel = 3'b000;
    ctrl = '0;
`ifdef BC_DP_HOST_PORT_EN
    host_we = 1'b0;
    host_addr = '0;
    host_wdata = '0;
    wr_val = 16'h1111;
`else
    wr_val = 16'hA5A5;
`endif
    dut.mem[12'h000] = 16'h0010;
    dut.mem[12'h005] = 16'h7800;
    dut.mem[12'h010] = 16'hBEEF;
    dut.mem[12'h011] = 16'h0005;
    dut.mem[12'h800] = 16'hFFFF;
    dut.mem[12'h801] = 16'h0001;
    dut.mem[12'h802] = 16'h00F0;
    dut.mem[12'h805] = 16'hA5A5;
    dut.mem[12'h806] = 16'h0123;

    // Reset, disturb state, reset again with MEM_WR asserted
    step(1, 3'd0, '0, 3'd0);
    exp_next(K_AR, 16'h0000, "rst0_ar"); exp_next(K_PC, 16'h0000, "rst0_pc");
    exp_next(K_AC, 16'h0000, "rst0_ac"); exp_next(K_E, 16'h0000, "rst0_e");
    step(0, 3'd0, b(AC_INR) | b(E_CMP) | b(PC_INR), 3'd0);
    exp_next(K_AC, 16'h0001, "ac_inr"); exp_next(K_E, 16'h0001, "e_cmp");
    exp_next(K_PC, 16'h0001, "pc_inr");
    step(0, 3'd6, b(AR_LD), 3'd0);
    exp_now(K_BUS, 16'h0010, "bus_mem0"); exp_next(K_AR, 16'h0010, "ar_ld_mem");
    step(1, 3'd5, b(MEM_WR) | b(IR_LD) | b(AC_INR), 3'd0);
    exp_next(K_AR, 16'h0000, "rst_ar"); exp_next(K_PC, 16'h0000, "rst_pc");
    exp_next(K_AC, 16'h0000, "rst_ac"); exp_next(K_IR, 16'h0000, "rst_ir");
    exp_next(K_E, 16'h0000, "rst_e");
    step(0, 3'd6, b(AR_LD), 3'd0);
    exp_next(K_AR, 16'h0010, "ar_reload");
    step(0, 3'd6, b(IR_LD), 3'd0);
    exp_now(K_BUS, 16'hBEEF, "rst_mem_kept"); exp_next(K_IR, 16'hBEEF, "ir_beef");
    step(0, 3'd0, b(AR_INR), 3'd0);
    exp_now(K_BUS, 16'h0000, "bus_zero"); exp_next(K_AR, 16'h0011, "ar_inr");
    step(0, 3'd6, b(PC_LD), 3'd0);
    exp_next(K_PC, 16'h0005, "pc_ld");

    // Fetch
    step(0, 3'd1, b(AR_LD), 3'd0);
    exp_now(K_BUS, 16'h0005, "bus_pc"); exp_next(K_AR, 16'h0005, "fetch_ar");
    step(0, 3'd6, b(IR_LD) | b(PC_INR), 3'd0);
    exp_now(K_BUS, 16'h7800, "bus_fetch"); exp_next(K_IR, 16'h7800, "fetch_ir");
    exp_next(K_PC, 16'h0006, "fetch_pc");
    step(0, 3'd4, b(AR_LD), 3'd0);
    exp_next(K_AR, 16'h0800, "fetch_ar_ir");

    // ADD with carry
    step(0, 3'd6, b(DR_LD), 3'd0);
    exp_now(K_BUS, 16'hFFFF, "bus_m800");
    step(0, 3'd0, b(AC_LD) | b(AR_INR), 3'd2);
    exp_next(K_AC, 16'hFFFF, "ac_ld_dr"); exp_next(K_AR, 16'h0801, "ar_801");
    step(0, 3'd6, b(DR_LD), 3'd0);
    step(0, 3'd3, b(AC_LD) | b(E_LD), 3'd1);
    exp_now(K_BUS, 16'h0001, "bus_dr");
    exp_next(K_AC, 16'h0000, "add_ac"); exp_next(K_E, 16'h0001, "add_e");

    // Complement and circulate
    step(0, 3'd0, b(AR_INR), 3'd0);
    step(0, 3'd6, b(DR_LD), 3'd0);
    step(0, 3'd0, b(AC_LD), 3'd2);
    exp_next(K_AC, 16'h00F0, "ac_f0");
    step(0, 3'd0, b(AC_LD), 3'd3);
    exp_next(K_AC, 16'hFF0F, "cma");
    step(0, 3'd0, b(AC_LD) | b(E_LD), 3'd4);
    exp_next(K_AC, 16'hFF87, "cir_ac"); exp_next(K_E, 16'h0001, "cir_e");
    step(0, 3'd0, b(AC_LD) | b(E_LD), 3'd5);
    exp_next(K_AC, 16'hFF0F, "cil_ac"); exp_next(K_E, 16'h0001, "cil_e");
    step(0, 3'd0, b(AC_LD) | b(E_LD), 3'd0);
    exp_next(K_AC, 16'h0000, "and_ac"); exp_next(K_E, 16'h0000, "and_e");
    step(0, 3'd0, b(AC_LD), 3'd1);
    exp_next(K_AC, 16'h00F0, "add_nc");
    step(0, 3'd0, b(AC_LD) | b(E_LD) | b(E_CMP), 3'd6);
    exp_next(K_AC, 16'h00F0, "hold_ac"); exp_next(K_E, 16'h0000, "e_ld_over_cmp");

    // Priority and wrap
    step(0, 3'd0, b(AC_CLR) | b(AC_LD) | b(AC_INR), 3'd2);
    exp_next(K_AC, 16'h0000, "ac_clr_prio");
    step(0, 3'd0, b(E_CMP), 3'd0);
    exp_next(K_E, 16'h0001, "e_cmp2");
    step(0, 3'd0, b(E_CLR) | b(E_CMP), 3'd0);
    exp_next(K_E, 16'h0000, "e_clr_prio");
    step(0, 3'd0, b(AC_LD) | b(E_CMP), 3'd3);
    exp_next(K_AC, 16'hFFFF, "cma_zero");
    step(0, 3'd0, b(AC_INR), 3'd0);
    exp_next(K_AC, 16'h0000, "ac_wrap"); exp_next(K_E, 16'h0001, "inr_keeps_e");
    step(0, 3'd0, b(AC_LD) | b(AC_INR), 3'd2);
    exp_next(K_AC, 16'h00F0, "ac_ld_over_inr");
    step(0, 3'd4, b(AR_LD), 3'd0);
    exp_next(K_AR, 16'h0800, "ar_trunc");
    step(0, 3'd6, b(PC_LD), 3'd0);
    exp_next(K_PC, 16'h0FFF, "pc_trunc");
    step(0, 3'd0, b(PC_INR), 3'd0);
    exp_next(K_PC, 16'h0000, "pc_wrap");
    step(0, 3'd0, b(PC_INR), 3'd0);
    step(0, 3'd6, b(PC_CLR) | b(PC_LD) | b(PC_INR), 3'd0);
    exp_next(K_PC, 16'h0000, "pc_clr_prio");
    step(0, 3'd2, b(AR_LD) | b(AR_INR), 3'd0);
    exp_now(K_BUS, 16'h0800, "bus_ar"); exp_next(K_AR, 16'h0800, "ar_ld_over_inr");
    step(0, 3'd2, b(PC_LD) | b(PC_INR), 3'd0);
    exp_next(K_PC, 16'h0800, "pc_ld_over_inr");

    // Memory write / read back
    for (int i = 0; i < 5; i++) step(0, 3'd0, b(AR_INR), 3'd0);
    exp_next(K_AR, 16'h0805, "ar_805");
    step(0, 3'd6, b(DR_LD), 3'd0);
    step(0, 3'd0, b(AC_LD) | b(AR_INR), 3'd2);
    exp_next(K_AC, 16'hA5A5, "ac_a5a5");
    step(0, 3'd6, b(AR_LD), 3'd0);
    exp_next(K_AR, 16'h0123, "ar_123");
    step(0, 3'd5, b(MEM_WR) | b(TR_LD), 3'd0);
    exp_now(K_BUS, 16'hA5A5, "bus_ac");
`ifdef BC_DP_HOST_PORT_EN
    host_we = 1'b1; host_addr = 12'h123; host_wdata = 16'h1111;
`endif
    step(0, 3'd6, b(IR_LD) | b(TR_INR), 3'd0);
`ifdef BC_DP_HOST_PORT_EN
    host_we = 1'b0;
`endif
    exp_now(K_BUS, wr_val, "mem_rdback"); exp_next(K_IR, wr_val, "ir_rdback");
    step(0, 3'd7, '0, 3'd0);
    exp_now(K_BUS, 16'hA5A6, "tr_ld_inr");
    step(0, 3'd7, b(TR_CLR) | b(TR_LD) | b(TR_INR), 3'd0);
    step(0, 3'd7, b(DR_INR), 3'd0);
    exp_now(K_BUS, 16'h0000, "tr_clr_prio");
    step(0, 3'd3, b(DR_CLR) | b(DR_LD), 3'd0);
    exp_now(K_BUS, 16'hA5A6, "dr_inr");
    step(0, 3'd3, '0, 3'd0);
    exp_now(K_BUS, 16'h0000, "dr_clr_prio");

`ifdef BC_DP_HOST_PORT_EN
    // Host write while reset is asserted
    step(1, 3'd0, '0, 3'd0);
    host_we = 1'b1; host_addr = 12'h000; host_wdata = 16'h2222;
    step(0, 3'd6, '0, 3'd0);
    host_we = 1'b0;
    exp_now(K_BUS, 16'h2222, "host_wr_in_rst");
`endif

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
      total_cnt += sb.size();
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
